// File: rtl/axi_lite_host_master.sv
// AXI-Lite initiator: turns a single-outstanding command/response interface
// into AW/W/B and AR/R bus transactions, with a timeout for a hung slave.
module axi_lite_host_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                stray_resp,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  input  logic [1:0]          m_axil_bresp,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;
  logic             active;
  logic             hs_any;

  // cmd_ready is a pure state decode, gated so it reads 0 during reset
  assign cmd_ready = rst_n && (state == IDLE);

  // Saturating timeout counter; expiry fires on the cycle it reaches the limit
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);
  assign active  = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_DATA);

  // Any bus handshake this cycle takes priority over timeout expiry
  always_comb begin
    hs_any = 1'b0;
    unique case (state)
      WR_REQ:  hs_any = (m_axil_awvalid && m_axil_awready) || (m_axil_wvalid && m_axil_wready);
      WR_RESP: hs_any = m_axil_bvalid;
      RD_REQ:  hs_any = m_axil_arready;
      RD_DATA: hs_any = m_axil_rvalid;
      default: hs_any = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b1;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= 2'b00;
      rsp_timeout    <= 1'b0;
      stray_resp     <= 1'b0;
    end else begin
      if (active) cnt <= cnt_inc;
      unique case (state)
        IDLE: begin
          // Late beats are absorbed here and only flagged
          if (m_axil_bvalid || m_axil_rvalid) stray_resp <= 1'b1;
          if (cmd_valid) begin
            cnt           <= '0;
            m_axil_bready <= 1'b0;
            m_axil_rready <= 1'b0;
            if (cmd_write) begin
              m_axil_awaddr  <= cmd_addr;
              m_axil_wdata   <= cmd_wdata;
              m_axil_wstrb   <= STRB_W'(cmd_wstrb);
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= WR_REQ;
            end else begin
              m_axil_araddr  <= cmd_addr;
              m_axil_arvalid <= 1'b1;
              state          <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= m_axil_bresp;
            rsp_timeout   <= 1'b0;
            state         <= RESP;
          end
        end
        RD_REQ: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            rsp_timeout   <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid     <= 1'b0;
            m_axil_bready <= 1'b1;
            m_axil_rready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Hung slave recovery: withdraw every valid and complete with SLVERR
      if (active && !hs_any && expire) begin
        m_axil_awvalid <= 1'b0;
        m_axil_wvalid  <= 1'b0;
        m_axil_arvalid <= 1'b0;
        m_axil_bready  <= 1'b0;
        m_axil_rready  <= 1'b0;
        rsp_valid      <= 1'b1;
        rsp_rdata      <= '0;
        rsp_resp       <= RESP_SLVERR;
        rsp_timeout    <= 1'b1;
        state          <= RESP;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_host_master.sv
// Self-checking bench for axi_lite_host_master: cycle-stepped slave model,
// directed scenarios plus randomized transactions against an expected-result model.
module tb_axi_lite_host_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_write;
  logic        cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, stray_resp;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;

  int n_cmp = 0;
  int n_err = 0;
  int last_aw_h, last_w_h;
  bit exp_stray = 1'b0;

  always #5 clk = ~clk;

  axi_lite_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .stray_resp(stray_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_slave();
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
    m_axil_bvalid  = 1'b0; m_axil_bresp  = 2'b00;
    m_axil_rvalid  = 1'b0; m_axil_rresp  = 2'b00; m_axil_rdata = 32'h0;
    rsp_ready      = 1'b0;
  endtask

  // One command end to end; the slave answers after the given wait counts
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_d, input int w_d, input int ar_d,
                         input int resp_d, input bit hang, input logic [1:0] sresp,
                         input logic [31:0] srdata, input int hold, input string tag);
    int aw_h = -1, w_h = -1, ar_h = -1, rsp_c = -1;
    int aw_seen = 0, w_seen = 0, ar_seen = 0, n_b = 0, n_r = 0, v_cnt = 0;
    bit stable = 1'b1, rsp_stable = 1'b1, done = 1'b0;
    logic [31:0] cap_addr = 32'hx, cap_data = 32'hx, rd0 = 32'h0;
    logic [3:0]  cap_strb = 4'hx;
    logic [1:0]  rr0 = 2'b00;
    logic        rt0 = 1'b0;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          exp_to;
    int          exp_rsp_c;

    // Expected outcome from the protocol rules
    if (hang) begin
      exp_to = 1'b1; exp_resp = 2'b10; exp_rdata = 32'h0; exp_rsp_c = TO + 1;
    end else if (wr) begin
      exp_to = 1'b0; exp_resp = sresp; exp_rdata = 32'h0;
      exp_rsp_c = imax(1 + aw_d, 1 + w_d) + 1 + resp_d + 1;
    end else begin
      exp_to = 1'b0; exp_resp = sresp; exp_rdata = srdata;
      exp_rsp_c = (1 + ar_d) + 1 + resp_d + 1;
    end

    @(negedge clk);
    check_eq({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;

    for (int k = 1; k < 200 && !done; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      if (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid) v_cnt++;

      m_axil_awready = 1'b0;
      if (m_axil_awvalid) begin
        if (m_axil_awaddr !== addr || aw_h >= 0) stable = 1'b0;
        if (!hang && aw_seen >= aw_d) begin m_axil_awready = 1'b1; aw_h = k; cap_addr = m_axil_awaddr; end
        aw_seen++;
      end
      m_axil_wready = 1'b0;
      if (m_axil_wvalid) begin
        if (m_axil_wdata !== data || m_axil_wstrb !== strb || w_h >= 0) stable = 1'b0;
        if (!hang && w_seen >= w_d) begin
          m_axil_wready = 1'b1; w_h = k; cap_data = m_axil_wdata; cap_strb = m_axil_wstrb;
        end
        w_seen++;
      end
      m_axil_arready = 1'b0;
      if (m_axil_arvalid) begin
        if (m_axil_araddr !== addr || ar_h >= 0) stable = 1'b0;
        if (!hang && ar_seen >= ar_d) begin m_axil_arready = 1'b1; ar_h = k; cap_addr = m_axil_araddr; end
        ar_seen++;
      end

      m_axil_bvalid = 1'b0;
      if (aw_h >= 0 && w_h >= 0 && k > aw_h && k > w_h && n_b == 0 &&
          k >= imax(aw_h, w_h) + 1 + resp_d) begin
        m_axil_bvalid = 1'b1; m_axil_bresp = sresp;
        if (m_axil_bready) n_b++;
      end
      m_axil_rvalid = 1'b0;
      if (ar_h >= 0 && k > ar_h && n_r == 0 && k >= ar_h + 1 + resp_d) begin
        m_axil_rvalid = 1'b1; m_axil_rresp = sresp; m_axil_rdata = srdata;
        if (m_axil_rready) n_r++;
      end

      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (rsp_c < 0) begin
          rsp_c = k; rd0 = rsp_rdata; rr0 = rsp_resp; rt0 = rsp_timeout;
        end else if (rsp_rdata !== rd0 || rsp_resp !== rr0 || rsp_timeout !== rt0) begin
          rsp_stable = 1'b0;
        end
        if (k - rsp_c >= hold) begin rsp_ready = 1'b1; done = 1'b1; end
      end
    end

    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".rdata"}, rd0, exp_rdata);
    check_eq({tag, ".resp"}, 32'(rr0), 32'(exp_resp));
    check_eq({tag, ".timeout"}, 32'(rt0), 32'(exp_to));
    check_eq({tag, ".rsp_cycle"}, 32'(rsp_c), 32'(exp_rsp_c));
    check_eq({tag, ".payload_stable"}, 32'(stable), 32'd1);
    check_eq({tag, ".rsp_stable"}, 32'(rsp_stable), 32'd1);
    if (hang) begin
      check_eq({tag, ".valid_cycles"}, 32'(v_cnt), 32'(TO));
    end else if (wr) begin
      check_eq({tag, ".awaddr"}, cap_addr, addr);
      check_eq({tag, ".wdata"}, cap_data, data);
      check_eq({tag, ".wstrb"}, 32'(cap_strb), 32'(strb));
      check_eq({tag, ".b_beats"}, 32'(n_b), 32'd1);
    end else begin
      check_eq({tag, ".araddr"}, cap_addr, addr);
      check_eq({tag, ".r_beats"}, 32'(n_r), 32'd1);
    end
    last_aw_h = aw_h;
    last_w_h  = w_h;

    @(negedge clk);
    clear_slave();
    check_eq({tag, ".rsp_dropped"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, ".stray"}, 32'(stray_resp), 32'(exp_stray));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    clear_slave();
    repeat (3) @(negedge clk);
    check_eq("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst.valids", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 32'd0);
    check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst.rsp_flags", 32'({rsp_resp, rsp_timeout, stray_resp}), 32'd0);
    check_eq("rst.addr_data", m_axil_awaddr | m_axil_wdata | m_axil_araddr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle.cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle.readies", 32'({m_axil_bready, m_axil_rready}), 32'd3);

    run_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0001_0001, 0, "version");
    run_txn(1'b1, 32'h10, 32'h0000_1000, 4'hF, 3, 0, 0, 0, 1'b0, 2'b00, 32'h0, 0, "wr_aw3");
    check_eq("wr_aw3.w_hs_cycle", 32'(last_w_h), 32'd1);
    check_eq("wr_aw3.aw_hs_cycle", 32'(last_aw_h), 32'd4);
    run_txn(1'b1, 32'h14, 32'hA5A5_0001, 4'h3, 0, 5, 0, 0, 1'b0, 2'b00, 32'h0, 0, "wr_w5");
    check_eq("wr_w5.aw_hs_cycle", 32'(last_aw_h), 32'd1);
    check_eq("wr_w5.w_hs_cycle", 32'(last_w_h), 32'd6);
    run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 2, 1, 1'b0, 2'b10, 32'hDEAD_BEEF, 0, "rd_slverr");
    run_txn(1'b0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 0, 1'b1, 2'b00, 32'h1234_5678, 0, "rd_hang");
    run_txn(1'b1, 32'h20, 32'h0000_0042, 4'hF, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 0, "wr_after_to");
    run_txn(1'b1, 32'h24, 32'h0BAD_F00D, 4'h5, 0, 0, 0, 0, 1'b1, 2'b00, 32'h0, 2, "wr_hang");
    run_txn(1'b0, 32'h28, 32'h0, 4'h0, 0, 0, 1, 0, 1'b0, 2'b01, 32'hCAFE_0123, 4, "rd_hold4");

    // Stray B and R beats while idle
    @(negedge clk);
    check_eq("stray.before", 32'(stray_resp), 32'd0);
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b11;
    @(negedge clk);
    m_axil_bvalid = 1'b0;
    check_eq("stray.set", 32'(stray_resp), 32'd1);
    check_eq("stray.cmd_ready", 32'(cmd_ready), 32'd1);
    m_axil_rvalid = 1'b1;
    @(negedge clk);
    m_axil_rvalid = 1'b0;
    exp_stray = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stray.sticky", 32'(stray_resp), 32'd1);

    for (int i = 0; i < 40; i++) begin
      bit hang;
      hang = ($urandom_range(0, 7) == 0);
      run_txn(1'($urandom), {24'h0, 8'($urandom) & 8'hFC}, $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3), hang, 2'($urandom), $urandom, $urandom_range(0, 3),
              $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a write request
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("mid_rst.pre_valids", 32'({m_axil_awvalid, m_axil_wvalid}), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst.valids", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 32'd0);
    check_eq("mid_rst.cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      check_eq("mid_rst.no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
    check_eq("mid_rst.idle", 32'(cmd_ready), 32'd1);
    check_eq("mid_rst.stray_clr", 32'(stray_resp), 32'd0);
    run_txn(1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0000_0007, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
